// File: rtl/icache_data_array.sv
// L1 I-cache storage: 2-way set-associative tag/valid/data array with per-set LRU.
// Optional ICACHE_FLUSH_EN adds a flush input that invalidates the whole array.
module icache_data_array #(
  parameter int ISET_INDEX_SIZE      = 4,
  parameter int ITAG_SIZE            = 24,
  parameter int IMEM_BLOCK_ADDR_SIZE = ITAG_SIZE + ISET_INDEX_SIZE,
  parameter int IBLOCK_SIZE_BITS     = 128
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef ICACHE_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic                            ren,
  input  logic                            memWen,
  input  logic [IMEM_BLOCK_ADDR_SIZE-1:0] blockAddr,
  input  logic [IBLOCK_SIZE_BITS-1:0]     dataIn,
  output logic                            hit,
  output logic [IBLOCK_SIZE_BITS-1:0]     dataOut
);

  localparam int NSETS = 1 << ISET_INDEX_SIZE;

  logic [ITAG_SIZE-1:0]        tag0  [NSETS];
  logic [ITAG_SIZE-1:0]        tag1  [NSETS];
  logic [IBLOCK_SIZE_BITS-1:0] data0 [NSETS];
  logic [IBLOCK_SIZE_BITS-1:0] data1 [NSETS];
  logic [NSETS-1:0]            valid0;
  logic [NSETS-1:0]            valid1;
  logic [NSETS-1:0]            lru;

  logic [ISET_INDEX_SIZE-1:0] idx;
  logic [ITAG_SIZE-1:0]       atag;
  logic                       match0;
  logic                       match1;
  logic                       do_flush;
  logic                       wr;
  logic                       way;

  assign idx  = blockAddr[ISET_INDEX_SIZE-1:0];
  assign atag = blockAddr[IMEM_BLOCK_ADDR_SIZE-1 -: ITAG_SIZE];

`ifdef ICACHE_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign match0 = valid0[idx] && (tag0[idx] == atag);
  assign match1 = valid1[idx] && (tag1[idx] == atag);
  assign wr     = memWen && !do_flush;

  // A refill in the same cycle suppresses the read entirely.
  assign hit = ren && !memWen && !do_flush && (match0 || match1);

  always_comb begin
    dataOut = '0;
    if (hit) dataOut = match0 ? data0[idx] : data1[idx];
  end

  // Victim: matching way, then first invalid way, then LRU.
  always_comb begin
    way = lru[idx];
    if (match0)            way = 1'b0;
    else if (match1)       way = 1'b1;
    else if (!valid0[idx]) way = 1'b0;
    else if (!valid1[idx]) way = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (do_flush) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (wr) begin
      if (way) valid1[idx] <= 1'b1;
      else     valid0[idx] <= 1'b1;
      lru[idx] <= ~way;
    end else if (hit) begin
      lru[idx] <= match0;
    end
  end

  // Tag/data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr) begin
      if (way) begin
        tag1[idx]  <= atag;
        data1[idx] <= dataIn;
      end else begin
        tag0[idx]  <= atag;
        data0[idx] <= dataIn;
      end
    end
  end

endmodule

// File: tb/tb_icache_data_array.sv
// Directed bench for icache_data_array: fills, LRU replacement, in-place rewrite,
// write-over-read priority, set independence and asynchronous reset.
module tb_icache_data_array;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         ren;
  logic         memWen;
  logic [27:0]  blockAddr;
  logic [127:0] dataIn;
  logic         hit;
  logic [127:0] dataOut;

  int checks;
  int failures;

  localparam logic [27:0]  A0 = {24'h000000, 4'h0};
  localparam logic [27:0]  T1 = {24'hFFFFFF, 4'h0};
  localparam logic [27:0]  T2 = {24'h07FFFF, 4'h0};
  localparam logic [27:0]  T3 = {24'hAFFFFF, 4'h0};
  localparam logic [27:0]  S15 = {24'hABCDEF, 4'hF};
  localparam logic [27:0]  S0X = {24'hABCDEF, 4'h0};
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] D2 = {5'b00000, {123{1'b1}}};
  localparam logic [127:0] D3 = {5'b10101, {123{1'b1}}};
  localparam logic [127:0] D4 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] D5 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
  localparam logic [127:0] D6 = 128'h5555_AAAA_5555_AAAA_3333_CCCC_3333_CCCC;

  icache_data_array dut (
    .clk(clk),
    .rst(rst),
`ifdef ICACHE_FLUSH_EN
    .flush(flush),
`endif
    .ren(ren),
    .memWen(memWen),
    .blockAddr(blockAddr),
    .dataIn(dataIn),
    .hit(hit),
    .dataOut(dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic eh, input logic [127:0] ed);
    checks++;
    assert (hit === eh && dataOut === ed) else begin
      failures++;
      $error("FAIL %s: hit=%b dataOut=%h, expected hit=%b dataOut=%h",
             tag, hit, dataOut, eh, ed);
    end
  endtask

  // Combinational lookup inside the low clock phase; no edge sees ren.
  task automatic look(input string tag, input logic [27:0] a,
                      input logic eh, input logic [127:0] ed);
    @(negedge clk);
    blockAddr = a;
    ren = 1'b1;
    #1;
    chk(tag, eh, ed);
    ren = 1'b0;
  endtask

  // Lookup held across a rising edge so the LRU bit updates.
  task automatic touch(input string tag, input logic [27:0] a,
                       input logic [127:0] ed);
    @(negedge clk);
    blockAddr = a;
    ren = 1'b1;
    #1;
    chk(tag, 1'b1, ed);
    @(negedge clk);
    ren = 1'b0;
  endtask

  task automatic fill(input logic [27:0] a, input logic [127:0] d);
    @(negedge clk);
    blockAddr = a;
    dataIn = d;
    memWen = 1'b1;
    @(negedge clk);
    memWen = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    flush = 1'b0;
    ren = 1'b1;
    memWen = 1'b0;
    blockAddr = A0;
    dataIn = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("in_reset", 1'b0, '0);
    rst = 1'b1;
    ren = 1'b0;

    look("cold_miss", A0, 1'b0, '0);

    fill(A0, '0);
    look("fill_w0", A0, 1'b1, '0);

    fill(T1, ONES);
    look("fill_w1", T1, 1'b1, ONES);
    touch("touch_a0", A0, '0);
    touch("touch_t1", T1, ONES);

    fill(T2, D2);
    look("evict_a0", A0, 1'b0, '0);
    look("t1_kept", T1, 1'b1, ONES);
    look("t2_in", T2, 1'b1, D2);

    fill(T3, D3);
    look("evict_t1", T1, 1'b0, '0);
    look("t2_kept", T2, 1'b1, D2);
    look("t3_in", T3, 1'b1, D3);

    touch("touch_t2", T2, D2);
    fill(T2, D4);
    look("rewrite_t2", T2, 1'b1, D4);
    look("rewrite_t3_kept", T3, 1'b1, D3);

    @(negedge clk);
    blockAddr = T3;
    dataIn = D5;
    memWen = 1'b1;
    ren = 1'b1;
    #1;
    chk("wr_over_rd", 1'b0, '0);
    @(negedge clk);
    memWen = 1'b0;
    ren = 1'b0;
    look("wr_over_rd_data", T3, 1'b1, D5);
    look("wr_over_rd_t2", T2, 1'b1, D4);

    fill(S15, D6);
    look("set15_hit", S15, 1'b1, D6);
    look("set0_same_tag", S0X, 1'b0, '0);
    look("set0_t2_kept", T2, 1'b1, D4);
    look("set0_t3_kept", T3, 1'b1, D5);

    @(negedge clk);
    blockAddr = T3;
    ren = 1'b1;
    #1;
    chk("pre_reset", 1'b1, D5);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset", 1'b0, '0);
    ren = 1'b0;
    blockAddr = A0;
    dataIn = D6;
    memWen = 1'b1;
    @(negedge clk);
    memWen = 1'b0;
    rst = 1'b1;

    look("post_rst_t3", T3, 1'b0, '0);
    look("post_rst_t2", T2, 1'b0, '0);
    look("post_rst_s15", S15, 1'b0, '0);
    look("post_rst_a0", A0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_data_array.md
Name: icache_data_array

Overview:
- Storage array of the L1 instruction cache: 2-way set-associative, with a tag, valid bit and data block per way and one LRU bit per set.
- Serves hit/miss lookups with block data for instruction fetch (ren).
- Accepts whole-block refills from memory (memWen), choosing the victim way itself.
- Sits between the I-cache controller and the memory refill path.

Parameters:
- ISET_INDEX_SIZE, 4: set index bits; 16 sets.
- ITAG_SIZE, 24: tag bits.
- IMEM_BLOCK_ADDR_SIZE, ITAG_SIZE+ISET_INDEX_SIZE (28): block address width.
- IBLOCK_SIZE_BITS, 128: data block width (4 x 32-bit instructions).
- Associativity fixed at 2 ways.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ren  in  1  lookup request.
- memWen  in  1  refill write from memory.
- blockAddr  in  IMEM_BLOCK_ADDR_SIZE  block address. Tag = upper ITAG_SIZE bits; set index = lower ISET_INDEX_SIZE bits.
- dataIn  in  IBLOCK_SIZE_BITS  refill block data.
- hit  out  1  lookup hit.
- dataOut  out  IBLOCK_SIZE_BITS  data of the hitting way.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears all valid bits and all LRU bits.
  - Data and tag contents are don't-care.
  - While reset is asserted, hit=0 and dataOut=0.
- Lookup (combinational, same cycle):
  - hit=1 iff ren=1, memWen=0, and some way w of set[index] has valid=1 and tag==addr tag.
  - dataOut = data of the hitting way; otherwise all zeros.
  - Both ways matching cannot occur, because refill rule 1 prevents duplicates.
- LRU update: on a rising edge with ren=1 and hit=1, LRU[set] is set to point at the non-hitting way. A miss leaves LRU unchanged.
- Refill: on a rising edge with memWen=1, the way is chosen by the first rule that applies:
  1. A valid way whose tag matches: overwrite it in place.
  2. Otherwise way 0 if invalid, else way 1 if invalid.
  3. Otherwise the way indicated by LRU[set].
- After the write: data=dataIn, tag=addr tag, valid=1, and LRU[set] points at the other way.
- memWen and ren both high: the write wins, hit=0, dataOut=0 and no LRU update from the read.
- Neither asserted: no state change.
- Reset mid-operation: any write in that cycle is discarded.
- Indexing: all sets, including index 0 and all-ones, are independent. The tag is compared over its full width (all-zero and all-one tags are legal).

Optional Feature:
- Macro ICACHE_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit), placed after rst.
  - flush=1 on a rising edge invalidates every way of every set and clears LRU.
  - flush has priority over memWen and ren in that cycle; hit=0 while flush=1.
- When not defined: no flush port; behaviour otherwise identical.

Test Plan:
- Reset, then ren=1 at blockAddr=0 -> hit=0, dataOut=0.
- Fill way 0: memWen=1, blockAddr=0, dataIn=0; then ren=1, addr 0 -> hit=1, dataOut=0.
- Fill way 1: memWen=1, tag all-ones, set 0, dataIn all-ones; then ren=1 on that address -> hit=1, dataOut all-ones; address 0 still hits.
- Replacement after the read of the all-ones tag (LRU now points at way 0):
  - Write tag {00000,1...1}, set 0, dataIn {00000,1...1} -> way 0 evicted; address 0 now misses; the all-ones tag still hits.
  - Write tag {10101,1...1}, set 0 -> way 1 evicted; the all-ones tag misses; both the {00000..} and {10101..} tags hit with matching data.
- Rewrite of a present tag with new data -> same way updated, no eviction; other way still hits. memWen and ren together -> hit=0, write performed.
- Assert rst low asynchronously between edges -> hit drops immediately; after release, all previously filled addresses miss.
